// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared types and constants for the sum accumulator slice
package sum_acc_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
endpackage

// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: sample input and byte-serial frame output handshakes
interface sum_accumulator_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [7:0] out_byte;
  logic out_valid;
  logic out_ready;
  logic out_last;
  modport master (
    output in_data, in_valid, out_ready,
    input in_ready, out_byte, out_valid, out_last
  );
  modport slave (
    input in_data, in_valid, out_ready,
    output in_ready, out_byte, out_valid, out_last
  );
endinterface

// File: rtl/sum_frame_tx.sv
// sum_frame_tx: snapshot registers and byte-serial frame sender
module sum_frame_tx
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             snap,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);
  localparam int NB = ACC_W / 8;
  localparam int IW = $clog2(NB + 1);
  localparam logic [IW-1:0] LAST = IW'(NB);
  state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [NB:0][7:0] frame;
  logic load;
  assign busy      = state == SEND;
  assign out_valid = ena & busy;
  assign out_last  = busy & (idx == LAST);
  assign out_byte  = frame[idx];
  always_comb begin
    state_d = state;
    idx_d   = idx;
    load    = 1'b0;
    if (state == IDLE) begin
      if (snap) begin
        state_d = SEND;
        idx_d   = '0;
        load    = 1'b1;
      end
    end else if (out_ready) begin
      state_d = out_last ? IDLE : SEND;
      idx_d   = out_last ? '0 : idx + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      frame <= '0;
    end else if (ena) begin
      state <= state_d;
      idx   <= idx_d;
      if (load) frame <= {cnt_in, acc_in};
    end
  end
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: saturating running total and sample count with framed readout
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  input  logic snap,
  sum_accumulator_if.slave bus,
  output logic busy,
  output logic ovf
);
  logic [ACC_W-1:0] acc, acc_next;
  logic [CNT_W-1:0] count, count_next;
  logic [ACC_W:0] sum;
  logic accept;
  assign bus.in_ready = ena & ~clr;
  assign accept       = bus.in_valid & bus.in_ready;
  assign sum          = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, bus.in_data};
  assign acc_next     = !accept ? acc : sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign count_next   = accept && count != CNT_MAX ? count + 1'b1 : count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (ena) begin
      acc   <= clr ? '0 : acc_next;
      count <= clr ? '0 : count_next;
      ovf   <= !clr & (ovf | (accept & sum[ACC_W]));
    end
  end
  sum_frame_tx #(.ACC_W(ACC_W)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .snap     (snap),
    .acc_in   (acc_next),
    .cnt_in   (count_next),
    .out_ready(bus.out_ready),
    .out_byte (bus.out_byte),
    .out_valid(bus.out_valid),
    .out_last (bus.out_last),
    .busy     (busy)
  );
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage for the 8-bit adder datapath in the TinyTapeout top.
- Consumes each 8-bit sum through a valid/ready handshake and keeps a saturating running total plus a sample count.
- On request, snapshots the total and count, then streams them out as a byte-serial frame over a valid/ready output port, for transfer off-chip through uo_out/uio_out.

Parameters:
- ACC_W, 16, accumulator width in bits; must be a multiple of 8 and at least 16.
- NB, ACC_W/8, derived: number of accumulator bytes per frame; not overridable.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- ena  in  1  global enable; when 0, all registers hold.
- in_data  in  8  sum from the adder stage.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  = ena & ~clr; a sample is accepted when in_valid & in_ready.
- clr  in  1  clears acc, count and ovf.
- snap  in  1  single-cycle request to capture and send a frame.
- out_byte  out  8  current frame byte.
- out_valid  out  1  frame byte is valid.
- out_ready  in  1  sink accepts the byte.
- out_last  out  1  high on the final (count) byte of the frame.
- busy  out  1  a frame is pending or being sent.
- ovf  out  1  sticky: the accumulator has saturated since the last clr or reset.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - acc, count, ovf, snapshot registers and byte index all become 0.
  - FSM goes to IDLE.
  - out_valid, out_last and busy are 0.
- ena=0:
  - No register updates.
  - in_ready=0 and out_valid=0.
  - Outputs resume their prior values when ena returns to 1.
- Accumulate, when a sample is accepted:
  - acc_next = acc + {0, in_data}, computed ACC_W+1 bits wide.
  - On carry-out, acc_next = all ones and ovf is set.
  - count_next = count+1, saturating at 255.
  - Register update latency is 1 cycle.
- Clear:
  - clr=1 sets acc, count and ovf to 0 at the next edge.
  - in_ready=0 that cycle, so no sample is accepted.
  - clr wins over any sample offered in the same cycle.
  - A frame already in progress is unaffected.
- FSM states: IDLE, SEND.
  - IDLE: busy=0, out_valid=0.
    - On snap=1, capture snap_acc and snap_cnt and set idx=0, then go to SEND.
    - Captured values are acc_next and count_next, so a sample accepted in the same cycle is included.
    - If clr is also high, the captured values are the pre-clear registered acc and count.
  - SEND: busy=1, out_valid=1.
    - out_byte = snap_acc byte idx (LS byte first) for idx < NB; out_byte = snap_cnt for idx = NB.
    - out_last = (idx == NB).
    - On out_valid & out_ready: if out_last, go to IDLE; otherwise idx+1.
    - out_byte is held stable while out_ready=0.
    - snap is ignored in SEND; there is no queuing.
  - At the default ACC_W=16, a frame is 3 bytes.
  - Back-to-back frames are possible: minimum 1 IDLE cycle between frames.
- Accumulation continues independently during SEND. in_ready never depends on the output side.
- Reset mid-frame aborts the frame with no partial completion. out_valid drops the cycle after the reset edge.
- No combinational path from out_ready to out_valid or out_byte.

Decomposition:
- Shared package sum_acc_pkg holds:
  - the state enum (IDLE, SEND);
  - the frame count-byte width (8);
  - the count saturation constant (8'hFF).
- One natural sub-module: sum_frame_tx, containing the snapshot registers, the byte mux and the SEND FSM.
- The top level keeps acc, count and ovf.

Test Plan:
- Reset, then 3 samples 0x10, 0x20, 0x05, then snap with out_ready=1 -> frame 0x35, 0x00, 0x03; out_last on the 3rd byte; busy for 3 cycles.
- acc preloaded to 0xFFF0 via samples, then sample 0x20 -> acc=0xFFFF, ovf=1; ovf stays 1 after a further sample 0x01; clr -> acc=0, count=0, ovf=0.
- clr and in_valid (0x44) in the same cycle -> in_ready=0, sample dropped; next snap -> frame 0x00, 0x00, 0x00.
- snap with in_valid (0x07) in the same cycle, acc=0x0100, count=1 -> frame 0x07, 0x01, 0x02.
- out_ready low for 4 cycles mid-frame -> out_byte held; samples accepted meanwhile change acc but not the frame; a snap during SEND is ignored.
- 300 samples of 0x01 -> count byte saturates at 0xFF, acc=0x012C; rst_n low mid-frame -> out_valid=0, busy=0, acc=0 the next cycle.
